pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//  Parametrised hazard, forwarding and flush controller for the 5-stage MIPS pipeline. Sits beside the
//  decode stage. Keeps a shift-register scoreboard of in-flight register writes (EX..WB). From it, drives:
//  - PC / IF-ID stall;
//  - per-stage flushes;
//  - ALU operand forwarding selects;
//  - a stall watchdog.
//  It replaces the unconditional PCSrc/Jump/Jr flush-free datapath with a general, depth-configurable scheme.
// PARAMETERS
//  REG_AW     5   register address width (32 GPRs; register 0 never tracked)
//  DEPTH      3   tracked stages after decode: index 1=EX, 2=MEM, ..., DEPTH=WB
//  LOAD_RDY   2   stage index at whose output load data first exists (2 = after MEM)
//  BR_STAGE   2   stage index where branch_taken is resolved (2 = MEM)
//  MAX_STALL  15  consecutive-stall count that raises hazard_timeout
// PORTS
//  Clk             in   1        clock, rising edge
//  Reset           in   1        asynchronous, active-low reset
//  id_valid        in   1        decode holds a valid instruction
//  id_rs, id_rt    in   REG_AW   decode source registers
//  id_use_rs/rt    in   1        instruction actually reads rs / rt
//  id_wr_en        in   1        instruction writes a register
//  id_rd           in   REG_AW   final destination (after RegDst/Jal mux)
//  id_is_load      in   1        instruction is a load
//  id_jump         in   1        j/jal/jr redirect taken in decode
//  branch_taken    in   1        branch resolved taken at stage BR_STAGE
//  stall           out  1        hold PC and IF/ID, insert bubble into ID/EX
//  flush_if_id     out  1        squash IF/ID register
//  flush_id_ex     out  1        squash ID/EX register
//  flush_to_br     out  1        squash all stages younger than BR_STAGE (ID/EX..BR_STAGE-1)
//  fwd_a, fwd_b    out  FW       FW=$clog2(DEPTH+1); 0=regfile, k=forward from stage k output
//  hazard_timeout  out  1        sticky watchdog flag
// BEHAVIOUR
//  - Reset low: scoreboard entries invalid, stall counter 0, hazard_timeout 0; all outputs 0 while low.
//  - Scoreboard entry k (1..DEPTH) = {v, rd, ld}. Every edge, entries shift k->k+1 (entry DEPTH drops).
//    - Entry 1 <= {id_valid & id_wr_en & (id_rd!=0) & ~stall & ~flush_id_ex, id_rd, id_is_load}.
//    - Stall inserts a bubble (v=0) into entry 1; older entries keep shifting.
//  - Match: entry k matches src s when v & rd==s & s!=0 & use_s & id_valid.
//  - Load-use stall: some matching entry has ld=1 and k < LOAD_RDY.
//    - Latency 1 cycle per missing stage (default: 1 bubble).
//  - Forward select: youngest (smallest k) matching entry whose result exists (ld ? k>=LOAD_RDY : k>=1).
//    - No match -> 0. Younger entries override older; same-cycle WB write is covered by k=DEPTH.
//  - Branch: branch_taken=1 -> flush_if_id=flush_id_ex=flush_to_br=1 and stall=0 (branch beats stall).
//    Entries with k<=BR_STAGE are invalidated at that edge (shift result v=0 up to BR_STAGE+1-1).
//  - Jump: id_jump & ~stall -> flush_if_id=1 only; ignored while stall=1 (re-evaluated next cycle).
//  - stall, flush_*, fwd_* are combinational from scoreboard registers + decode inputs (same cycle).
//  - Watchdog: stall_cnt (width $clog2(MAX_STALL+1)) increments on each stall cycle, clears on a non-stall
//    cycle, saturates at MAX_STALL; reaching MAX_STALL sets hazard_timeout until Reset.
//  - Reset asserted mid-stall: counter and scoreboard clear immediately; no residual stall after release.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//    - adds out ports stall_total [31:0] and flush_total [31:0].
//    - stall_total: +1 per stall cycle; flush_total: +1 per cycle with branch_taken or accepted jump.
//    - both wrap at 2^32 and reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset low 3 cycles, random inputs -> all outputs 0; release -> stall=0, fwd_a=fwd_b=0.
//  2. add $3 then sub uses $3 next cycle -> fwd_a=1 (EX), no stall; one cycle later -> fwd_a=2.
//  3. lw $4 then add uses $4 as rt -> stall=1 exactly 1 cycle, then fwd_b=2; $0 dest/source never stalls.
//  4. Load-use stall same cycle as branch_taken -> stall=0; flush_if_id, flush_id_ex, flush_to_br all 1;
//     next cycle entries 1..2 invalid.
//  5. Hold a load-use hazard by re-issuing 15 cycles (forced) -> hazard_timeout=1 at 15th, sticky until Reset.
//  6. HAZARD_STATS_EN: 4 stalls + 2 branches -> stall_total=4, flush_total=2; undefined build elaborates without ports.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline, driven by an in-flight write scoreboard.
// Optional HAZARD_STATS_EN adds free-running stall_total / flush_total counters.
module pipeline_hazard_unit #(
  parameter  int REG_AW    = 5,
  parameter  int DEPTH     = 3,
  parameter  int LOAD_RDY  = 2,
  parameter  int BR_STAGE  = 2,
  parameter  int MAX_STALL = 15,
  localparam int FW        = $clog2(DEPTH + 1),
  localparam int SCW       = $clog2(MAX_STALL + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              id_jump,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_to_br,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              hazard_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_total,
  output logic [31:0]       flush_total
`endif
);

  logic [DEPTH:1]             v_q, v_d;
  logic [DEPTH:1]             ld_q, ld_d;
  logic [DEPTH:1][REG_AW-1:0] rd_q, rd_d;
  logic [SCW-1:0]             stall_cnt_q, stall_cnt_d;
  logic                       timeout_q, timeout_d;

  logic          load_use_s;
  logic          stall_s;
  logic          hit_a_s, hit_b_s, rdy_s;
  logic [FW-1:0] fwd_a_s, fwd_b_s;

  // Scoreboard lookup: walk oldest to youngest so the youngest ready producer wins the forward select.
  always_comb begin
    load_use_s = 1'b0;
    fwd_a_s    = '0;
    fwd_b_s    = '0;
    hit_a_s    = 1'b0;
    hit_b_s    = 1'b0;
    rdy_s      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      hit_a_s    = v_q[k] && (rd_q[k] == id_rs) && (id_rs != '0) && id_use_rs && id_valid;
      hit_b_s    = v_q[k] && (rd_q[k] == id_rt) && (id_rt != '0) && id_use_rt && id_valid;
      rdy_s      = ld_q[k] ? (k >= LOAD_RDY) : 1'b1;
      load_use_s = load_use_s | ((hit_a_s | hit_b_s) & ~rdy_s);
      if (hit_a_s && rdy_s) begin
        fwd_a_s = FW'(k);
      end else begin
        fwd_a_s = fwd_a_s;
      end
      if (hit_b_s && rdy_s) begin
        fwd_b_s = FW'(k);
      end else begin
        fwd_b_s = fwd_b_s;
      end
    end
  end

  // A taken branch squashes everything younger than it, so it overrides any load-use stall.
  assign stall_s = load_use_s & ~branch_taken;

  // Scoreboard shift: new entry from decode, then branch squash of the slots younger than the branch.
  always_comb begin
    v_d     = '0;
    ld_d    = '0;
    rd_d    = '0;
    v_d[1]  = id_valid & id_wr_en & (id_rd != '0) & ~stall_s & ~branch_taken;
    rd_d[1] = id_rd;
    ld_d[1] = id_is_load;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      rd_d[k] = rd_q[k-1];
      ld_d[k] = ld_q[k-1];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      v_d[k] = v_d[k] & ~(branch_taken & (k <= BR_STAGE));
    end
  end

  // Watchdog: count consecutive stall cycles, saturate, and latch the timeout flag.
  always_comb begin
    if (!stall_s) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == SCW'(MAX_STALL)) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (stall_cnt_d == SCW'(MAX_STALL));
  end

  // Scoreboard and watchdog registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v_q         <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      v_q         <= v_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Decode-facing controls are combinational; forced low while Reset is held.
  assign stall          = Reset & stall_s;
  assign flush_if_id    = Reset & (branch_taken | (id_jump & ~stall_s));
  assign flush_id_ex    = Reset & branch_taken;
  assign flush_to_br    = Reset & branch_taken;
  assign fwd_a          = Reset ? fwd_a_s : '0;
  assign fwd_b          = Reset ? fwd_b_s : '0;
  assign hazard_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_total_q, stall_total_d;
  logic [31:0] flush_total_q, flush_total_d;

  // Event counters; wrap naturally at 2^32.
  always_comb begin
    stall_total_d = stall_total_q + {31'd0, stall_s};
    flush_total_d = flush_total_q + {31'd0, (branch_taken | (id_jump & ~stall_s))};
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_total_q <= 32'd0;
      flush_total_q <= 32'd0;
    end else begin
      stall_total_q <= stall_total_d;
      flush_total_q <= flush_total_d;
    end
  end

  assign stall_total = stall_total_q;
  assign flush_total = flush_total_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: per-cycle vector table plus reset and watchdog sequences.
module tb_pipeline_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr_en;
    logic [4:0] rd;
    logic       ld;
    logic       jmp;
    logic       br;
    logic       e_stall;
    logic       e_fif;
    logic       e_fie;
    logic       e_fbr;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_jump, branch_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       stall, flush_if_id, flush_id_ex, flush_to_br, hazard_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic       stall2, fif2, fie2, fbr2, timeout2;
  logic [4:0] fwd_a2, fwd_b2;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_total, flush_total, stall_total2, flush_total2;
`endif

  int   tests = 0;
  int   fails = 0;
  vec_t tbl[21];

  always #5 Clk = ~Clk;

  pipeline_hazard_unit dut (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_jump(id_jump), .branch_taken(branch_taken),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_to_br(flush_to_br),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hazard_timeout(hazard_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_total(stall_total), .flush_total(flush_total)
`endif
  );

  // Deep instance: loads become forwardable only at stage 16, giving 15 back-to-back stall cycles.
  pipeline_hazard_unit #(.DEPTH(16), .LOAD_RDY(16), .BR_STAGE(2), .MAX_STALL(15)) dut2 (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_jump(id_jump), .branch_taken(branch_taken),
    .stall(stall2), .flush_if_id(fif2), .flush_id_ex(fie2), .flush_to_br(fbr2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .hazard_timeout(timeout2)
`ifdef HAZARD_STATS_EN
    , .stall_total(stall_total2), .flush_total(flush_total2)
`endif
  );

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic wr, input logic [4:0] rd,
                              input logic ld, input logic jmp, input logic br,
                              input logic st, input logic fif, input logic fie, input logic fbr,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r = '{v, rs, rt, urs, urt, wr, rd, ld, jmp, br, st, fif, fie, fbr, fa, fb};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_use_rs    = v.use_rs;
    id_use_rt    = v.use_rt;
    id_wr_en     = v.wr_en;
    id_rd        = v.rd;
    id_is_load   = v.ld;
    id_jump      = v.jmp;
    branch_taken = v.br;
  endtask

  task automatic idle();
    drive('0);
  endtask

  initial begin
    int   exp_stalls;
    int   exp_flushes;
    vec_t lw4;
    vec_t use4;

    //            v rs rt urs urt wr rd ld j br | st fif fie fbr fa fb
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 2, 1, 1, 1, 5, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 3, 7, 1, 1, 1, 6, 0, 0, 0,   0, 0, 0, 0, 2, 0);
    tbl[3]  = mk(1, 3, 5, 1, 1, 1, 8, 0, 0, 0,   0, 0, 0, 0, 3, 2);
    tbl[4]  = mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 0,   0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(1, 9, 6, 1, 0, 1, 8, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 8, 8, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
    tbl[7]  = mk(1, 8, 0, 1, 0, 1, 4, 1, 0, 0,   0, 0, 0, 0, 2, 0);
    tbl[8]  = mk(1, 1, 4, 1, 1, 1, 10, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 1, 4, 1, 1, 1, 10, 0, 0, 0,  0, 0, 0, 0, 0, 2);
    tbl[10] = mk(1, 4, 0, 1, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 3, 0);
    tbl[11] = mk(1, 0, 10, 1, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[12] = mk(1, 10, 11, 1, 1, 1, 14, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 12, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 12, 14, 1, 1, 1, 13, 0, 0, 1, 0, 1, 1, 1, 0, 2);
    tbl[15] = mk(1, 12, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 31, 0, 1, 0,  0, 1, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 20, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 20, 31, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2);
    tbl[19] = mk(1, 20, 31, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2, 3);
    tbl[20] = mk(0, 20, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    lw4  = mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    use4 = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held low with random decode inputs: every output must stay 0.
    Reset = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      id_valid     = 1'($urandom_range(0, 1));
      id_rs        = 5'($urandom_range(0, 31));
      id_rt        = 5'($urandom_range(0, 31));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      id_wr_en     = 1'($urandom_range(0, 1));
      id_rd        = 5'($urandom_range(0, 31));
      id_is_load   = 1'($urandom_range(0, 1));
      id_jump      = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      #1;
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst flush_if_id", 32'(flush_if_id), 32'd0);
      chk("rst flush_id_ex", 32'(flush_id_ex), 32'd0);
      chk("rst flush_to_br", 32'(flush_to_br), 32'd0);
      chk("rst fwd_a", 32'(fwd_a), 32'd0);
      chk("rst fwd_b", 32'(fwd_b), 32'd0);
      chk("rst timeout", 32'(hazard_timeout), 32'd0);
      chk("rst stall2", 32'(stall2), 32'd0);
    end
    @(negedge Clk);
    idle();
    Reset = 1'b1;
    #1;
    chk("release stall", 32'(stall), 32'd0);
    chk("release fwd_a", 32'(fwd_a), 32'd0);
    chk("release fwd_b", 32'(fwd_b), 32'd0);

    // Table: each record is one decode cycle, checked mid-cycle before the committing edge.
    exp_stalls  = 0;
    exp_flushes = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge Clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d flush_if_id", i), 32'(flush_if_id), 32'(tbl[i].e_fif));
      chk($sformatf("v%0d flush_id_ex", i), 32'(flush_id_ex), 32'(tbl[i].e_fie));
      chk($sformatf("v%0d flush_to_br", i), 32'(flush_to_br), 32'(tbl[i].e_fbr));
      chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].e_fa));
      chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].e_fb));
      exp_stalls  += int'(tbl[i].e_stall);
      exp_flushes += int'(tbl[i].br | (tbl[i].jmp & ~tbl[i].e_stall));
    end
    @(negedge Clk);
    idle();
    #1;
    chk("table timeout", 32'(hazard_timeout), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("stall_total", stall_total, 32'(exp_stalls));
    chk("flush_total", flush_total, 32'(exp_flushes));
`endif

    // Reset asserted in the middle of a load-use stall.
    @(negedge Clk);
    drive(lw4);
    @(negedge Clk);
    drive(use4);
    #1;
    chk("pre-reset stall", 32'(stall), 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid-stall reset", 32'(stall), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("post-reset stall", 32'(stall), 32'd0);
    chk("post-reset fwd_a", 32'(fwd_a), 32'd0);

    // Watchdog on the deep instance: 15 consecutive stalls, then the load forwards from stage 16.
    @(negedge Clk);
    idle();
    @(negedge Clk);
    drive(lw4);
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clk);
      drive(use4);
      #1;
      chk($sformatf("wd c%0d stall2", c), 32'(stall2), 32'(c <= 15));
      chk($sformatf("wd c%0d timeout2", c), 32'(timeout2), 32'(c == 16));
    end
    chk("wd fwd_a2", 32'(fwd_a2), 32'd16);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      idle();
      #1;
      chk("wd sticky", 32'(timeout2), 32'd1);
    end
    chk("wd short stalls", 32'(hazard_timeout), 32'd0);
    Reset = 1'b0;
    #1;
    chk("wd cleared", 32'(timeout2), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
